// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 device-to-host receive path.
package ps2_rx_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus stability filter for one raw PS/2 line; idles high.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic filt_o
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   synced_s;

    assign synced_s = sync_q[SYNC_STAGES-1];
    assign filt_o   = filt_q;

    // Stability counter: a new level is adopted only after FILT_LEN disagreeing samples.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (synced_s != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = synced_s;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchroniser chain and filter state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 receive front end: line conditioning, 11-bit frame deserialiser with
// start/parity/stop checks, inter-edge timeout and a one-entry valid/ready output.
module ps2_rx_frame
    import ps2_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     ps2_clk_i,
    input  logic                     ps2_dat_i,
    output logic [PS2_DATA_BITS-1:0] dat_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     par_err_o,
    output logic                     frm_err_o,
    output logic                     tmo_o,
    output logic                     ovf_o
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic clk_filt_s, dat_filt_s, good_s;
    logic clk_prev_q, fe_q;

    ps2_state_e               state_q, state_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic                     par_q, par_d;
    logic [TW-1:0]            tmo_cnt_q, tmo_cnt_d;
    logic [PS2_DATA_BITS-1:0] dat_q, dat_d;
    logic                     valid_q, valid_d;
    logic                     par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic                     tmo_q, tmo_d, ovf_q, ovf_d;

    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk_i (clk_i), .rst_i (rst_i), .raw_i (ps2_clk_i), .filt_o (clk_filt_s)
    );

    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_dat_filt (
        .clk_i (clk_i), .rst_i (rst_i), .raw_i (ps2_dat_i), .filt_o (dat_filt_s)
    );

    assign dat_o     = dat_q;
    assign valid_o   = valid_q;
    assign par_err_o = par_err_q;
    assign frm_err_o = frm_err_q;
    assign tmo_o     = tmo_q;
    assign ovf_o     = ovf_q;

    // Frame FSM, timeout supervision and holding-register update.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_cnt_d = tmo_cnt_q;
        dat_d     = dat_q;
        valid_d   = valid_q;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        tmo_d     = 1'b0;
        ovf_d     = 1'b0;
        good_s    = 1'b0;
        if (!en_i) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            shift_d   = '0;
            tmo_cnt_d = '0;
            valid_d   = 1'b0;
        end else begin
            if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
            if (fe_q) begin
                tmo_cnt_d = '0;
                case (state_q)
                    ST_IDLE: begin
                        if (!dat_filt_s) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = 3'd0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        // LSB arrives first, so after eight shifts bit 0 sits at index 0.
                        shift_d = {dat_filt_s, shift_q[PS2_DATA_BITS-1:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_PARITY;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        par_d   = dat_filt_s;
                        state_d = ST_STOP;
                    end
                    ST_STOP: begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = 3'd0;
                        if (!odd_parity_ok(shift_q, par_q)) begin
                            par_err_d = 1'b1;
                        end else if (!dat_filt_s) begin
                            frm_err_d = 1'b1;
                        end else begin
                            good_s = 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end else if (state_q == ST_IDLE) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_LAST) begin
                state_d   = ST_IDLE;
                bit_cnt_d = 3'd0;
                tmo_cnt_d = '0;
                tmo_d     = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
            // A byte consumed this very cycle frees the slot for the new one.
            if (good_s) begin
                if (!valid_q || ready_i) begin
                    dat_d   = shift_q;
                    valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                ovf_d = 1'b0;
            end
        end
    end

    // State, edge detector and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_prev_q <= 1'b1;
            fe_q       <= 1'b0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_cnt_q  <= '0;
            dat_q      <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            tmo_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            clk_prev_q <= clk_filt_s;
            fe_q       <= clk_prev_q & ~clk_filt_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_cnt_q  <= tmo_cnt_d;
            dat_q      <= dat_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            tmo_q      <= tmo_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: hand-built PS/2 frames, pulse counting monitor.
module tb_ps2_rx_frame;
    import ps2_rx_pkg::*;

    localparam int HALF = 12;
    localparam int GAP  = 40;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       en_i = 1'b1;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_dat_i = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] dat_o;
    logic       valid_o, par_err_o, frm_err_o, tmo_o, ovf_o;

    int n_chk = 0;
    int n_err = 0;
    int n_par = 0, n_frm = 0, n_tmo = 0, n_ovf = 0, n_multi = 0;
    logic [7:0] acc_q[$];

    ps2_rx_frame dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .ps2_clk_i (ps2_clk_i),
        .ps2_dat_i (ps2_dat_i),
        .dat_o     (dat_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .par_err_o (par_err_o),
        .frm_err_o (frm_err_o),
        .tmo_o     (tmo_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Pulse counters and record of every byte taken by the consumer.
    always @(negedge clk_i) begin
        if (par_err_o) n_par++;
        if (frm_err_o) n_frm++;
        if (tmo_o) n_tmo++;
        if (ovf_o) n_ovf++;
        if ((32'(par_err_o) + 32'(frm_err_o) + 32'(tmo_o) + 32'(ovf_o)) > 32'd1) n_multi++;
        if (valid_o && ready_i) acc_q.push_back(dat_o);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip, input logic stop);
        return {stop, (~^d) ^ flip, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat_i = bits[i];
            if (i == glitch_bit) begin
                tick(4);
                ps2_clk_i = 1'b0;
                tick(2);
                ps2_clk_i = 1'b1;
                tick(HALF - 6);
            end else begin
                tick(HALF);
            end
            ps2_clk_i = 1'b0;
            tick(HALF);
            ps2_clk_i = 1'b1;
        end
        ps2_dat_i = 1'b1;
        tick(GAP);
    endtask

    task automatic acc_at(input string tag, input int idx, input logic [7:0] exp);
        if (acc_q.size() > idx) check_eq(tag, 32'(acc_q[idx]), 32'(exp));
        else check_eq({tag, "_cnt"}, 32'(acc_q.size()), 32'(idx + 1));
    endtask

    initial begin
        tick(3);
        @(negedge clk_i);
        check_eq("rst_dat", 32'(dat_o), 32'h0);
        check_eq("rst_valid", 32'(valid_o), 32'h0);
        check_eq("rst_pulses", {28'd0, par_err_o, frm_err_o, tmo_o, ovf_o}, 32'h0);
        check_eq("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst_i = 1'b0;
        tick(10);

        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, -1);
        acc_at("t1_byte", 0, 8'h1C);
        check_eq("t1_valid_after", 32'(valid_o), 32'h0);
        check_eq("t1_errs", 32'(n_par + n_frm + n_tmo + n_ovf), 32'd0);

        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11, -1);
        check_eq("t2_par", 32'(n_par), 32'd1);
        check_eq("t2_nobyte", 32'(acc_q.size()), 32'd1);
        send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 11, -1);
        acc_at("t2_byte", 1, 8'hF0);

        send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 4, -1);
        tick(16300);
        check_eq("t3_tmo_early", 32'(n_tmo), 32'd0);
        tick(200);
        check_eq("t3_tmo", 32'(n_tmo), 32'd1);
        check_eq("t3_state", 32'(dut.state_q), 32'(ST_IDLE));
        send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 11, -1);
        acc_at("t3_byte", 2, 8'h5A);

        ready_i = 1'b0;
        send_bits(mk_frame(8'h12, 1'b0, 1'b1), 11, -1);
        send_bits(mk_frame(8'h34, 1'b0, 1'b1), 11, -1);
        check_eq("t4_hold_dat", 32'(dat_o), 32'h12);
        check_eq("t4_hold_valid", 32'(valid_o), 32'h1);
        check_eq("t4_ovf", 32'(n_ovf), 32'd1);
        ready_i = 1'b1;
        tick(2);
        check_eq("t4_drained", 32'(valid_o), 32'h0);
        acc_at("t4_byte", 3, 8'h12);
        check_eq("t4_count", 32'(acc_q.size()), 32'd4);

        send_bits(mk_frame(8'hAA, 1'b0, 1'b1), 11, 4);
        acc_at("t5_byte", 4, 8'hAA);
        check_eq("t5_errs", 32'(n_par + n_frm), 32'd1);

        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11, -1);
        check_eq("t6_frm", 32'(n_frm), 32'd1);
        check_eq("t6_par", 32'(n_par), 32'd1);

        ready_i = 1'b0;
        send_bits(mk_frame(8'h12, 1'b0, 1'b1), 11, -1);
        check_eq("t7_valid", 32'(valid_o), 32'h1);
        en_i = 1'b0;
        tick(2);
        check_eq("t7_flush", 32'(valid_o), 32'h0);
        en_i = 1'b1;
        tick(4);

        send_bits(mk_frame(8'h77, 1'b0, 1'b1), 11, -1);
        check_eq("t8_pre_dat", 32'(dat_o), 32'h77);
        send_bits(mk_frame(8'h3C, 1'b0, 1'b1), 5, -1);
        check_eq("t8_mid_state", 32'(dut.state_q), 32'(ST_DATA));
        rst_i = 1'b1;
        tick(2);
        check_eq("t8_rst_dat", 32'(dat_o), 32'h0);
        check_eq("t8_rst_valid", 32'(valid_o), 32'h0);
        check_eq("t8_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst_i = 1'b0;
        ready_i = 1'b1;
        tick(10);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, -1);
        acc_at("t8_byte", 5, 8'h1C);

        check_eq("end_par", 32'(n_par), 32'd1);
        check_eq("end_frm", 32'(n_frm), 32'd1);
        check_eq("end_tmo", 32'(n_tmo), 32'd1);
        check_eq("end_ovf", 32'(n_ovf), 32'd1);
        check_eq("end_exclusive", 32'(n_multi), 32'd0);
        check_eq("end_count", 32'(acc_q.size()), 32'd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
